// File: rtl/mem_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_read_arbiter
// Purpose  : Round-robin arbiter sharing one AXI read-translation port between
//            instruction fetch (I) and data load (D), with a read watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module mem_read_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  CLK,
    input  logic                  RST,
    // instruction requester
    input  logic                  I_RDEN,
    input  logic [ADDR_WIDTH-1:0] I_RADDR,
    output logic                  I_RVALID,
    output logic [DATA_WIDTH-1:0] I_RDATA,
    output logic                  I_STALL,
    // data requester
    input  logic                  D_RDEN,
    input  logic [ADDR_WIDTH-1:0] D_RADDR,
    output logic                  D_RVALID,
    output logic [DATA_WIDTH-1:0] D_RDATA,
    output logic                  D_STALL,
    // translator side
    output logic                  M_RSELECT,
    output logic                  M_RDEN,
    output logic [ADDR_WIDTH-1:0] M_RIADDR,
    input  logic                  M_LOADING,
    input  logic                  M_RVALID,
    input  logic [ADDR_WIDTH-1:0] M_ROADDR,
    input  logic [DATA_WIDTH-1:0] M_RDATA,
    output logic                  ERR
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int            CW        = 16;
    localparam logic [CW-1:0] C_TIMEOUT = CW'(TIMEOUT);
    localparam logic [CW-1:0] C_CNT_MAX = {CW{1'b1}};
    localparam logic          C_ID_I    = 1'b0;
    localparam logic          C_ID_D    = 1'b1;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic                  r_rr_ptr;
    logic                  w_rr_ptr_nxt;
    logic                  r_gnt_id;
    logic                  w_gnt_id_nxt;
    logic [CW-1:0]         r_cnt;
    logic [CW-1:0]         w_cnt_nxt;
    logic                  r_m_rden;
    logic                  w_m_rden_nxt;
    logic [ADDR_WIDTH-1:0] r_m_riaddr;
    logic [ADDR_WIDTH-1:0] w_m_riaddr_nxt;
    logic                  r_i_rvalid;
    logic                  w_i_rvalid_nxt;
    logic [DATA_WIDTH-1:0] r_i_rdata;
    logic [DATA_WIDTH-1:0] w_i_rdata_nxt;
    logic                  r_d_rvalid;
    logic                  w_d_rvalid_nxt;
    logic [DATA_WIDTH-1:0] r_d_rdata;
    logic [DATA_WIDTH-1:0] w_d_rdata_nxt;
    logic                  r_err;
    logic                  w_err_nxt;

    logic                  w_req_any;
    logic                  w_gnt_id;
    logic [ADDR_WIDTH-1:0] w_gnt_addr;
    logic                  w_match;
    logic                  w_timeout;
    logic                  w_unused_loading;

    // Translator busy flag carries no decision weight in this arbiter.
    assign w_unused_loading = M_LOADING;

    assign w_req_any  = I_RDEN | D_RDEN;
    // With both requesting the pointer decides; otherwise the lone requester wins.
    assign w_gnt_id   = (I_RDEN && D_RDEN) ? r_rr_ptr : (D_RDEN ? C_ID_D : C_ID_I);
    assign w_gnt_addr = (w_gnt_id == C_ID_D) ? D_RADDR : I_RADDR;
    assign w_match    = M_RVALID && (M_ROADDR == r_m_riaddr);
    assign w_timeout  = (r_cnt >= C_TIMEOUT);

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= S_IDLE;
            r_rr_ptr   <= C_ID_I;
            r_gnt_id   <= C_ID_I;
            r_cnt      <= '0;
            r_m_rden   <= 1'b0;
            r_m_riaddr <= '0;
            r_i_rvalid <= 1'b0;
            r_i_rdata  <= '0;
            r_d_rvalid <= 1'b0;
            r_d_rdata  <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_gnt_id   <= w_gnt_id_nxt;
            r_cnt      <= w_cnt_nxt;
            r_m_rden   <= w_m_rden_nxt;
            r_m_riaddr <= w_m_riaddr_nxt;
            r_i_rvalid <= w_i_rvalid_nxt;
            r_i_rdata  <= w_i_rdata_nxt;
            r_d_rvalid <= w_d_rvalid_nxt;
            r_d_rdata  <= w_d_rdata_nxt;
            r_err      <= w_err_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_req_any) begin
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                if (w_match || w_timeout) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output / datapath next values
    // ------------------------------------------------------------------
    always_comb begin
        w_rr_ptr_nxt   = r_rr_ptr;
        w_gnt_id_nxt   = r_gnt_id;
        w_cnt_nxt      = r_cnt;
        w_m_rden_nxt   = r_m_rden;
        w_m_riaddr_nxt = r_m_riaddr;
        w_i_rvalid_nxt = r_i_rvalid;
        w_i_rdata_nxt  = r_i_rdata;
        w_d_rvalid_nxt = r_d_rvalid;
        w_d_rdata_nxt  = r_d_rdata;
        w_err_nxt      = r_err;
        case (r_state)
            S_IDLE: begin
                if (w_req_any) begin
                    w_m_rden_nxt   = 1'b1;
                    w_m_riaddr_nxt = w_gnt_addr;
                    w_gnt_id_nxt   = w_gnt_id;
                    w_rr_ptr_nxt   = ~w_gnt_id;
                    w_cnt_nxt      = '0;
                end
            end
            S_BUSY: begin
                // A match on the final counted cycle still beats the watchdog.
                if (w_match) begin
                    w_m_rden_nxt = 1'b0;
                    if (r_gnt_id == C_ID_D) begin
                        w_d_rvalid_nxt = 1'b1;
                        w_d_rdata_nxt  = M_RDATA;
                    end else begin
                        w_i_rvalid_nxt = 1'b1;
                        w_i_rdata_nxt  = M_RDATA;
                    end
                end else if (w_timeout) begin
                    w_m_rden_nxt = 1'b0;
                    w_err_nxt    = 1'b1;
                    if (r_gnt_id == C_ID_D) begin
                        w_d_rvalid_nxt = 1'b1;
                        w_d_rdata_nxt  = '0;
                    end else begin
                        w_i_rvalid_nxt = 1'b1;
                        w_i_rdata_nxt  = '0;
                    end
                end else if (r_cnt != C_CNT_MAX) begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            S_DONE: begin
                w_i_rvalid_nxt = 1'b0;
                w_i_rdata_nxt  = '0;
                w_d_rvalid_nxt = 1'b0;
                w_d_rdata_nxt  = '0;
                w_err_nxt      = 1'b0;
            end
            default: begin
                w_m_rden_nxt = 1'b0;
            end
        endcase
    end

    assign M_RDEN    = r_m_rden;
    assign M_RSELECT = r_m_rden;
    assign M_RIADDR  = r_m_riaddr;
    assign I_RVALID  = r_i_rvalid;
    assign I_RDATA   = r_i_rdata;
    assign D_RVALID  = r_d_rvalid;
    assign D_RDATA   = r_d_rdata;
    assign ERR       = r_err;
    assign I_STALL   = I_RDEN && !r_i_rvalid;
    assign D_STALL   = D_RDEN && !r_d_rvalid;

endmodule
`default_nettype wire
